// File: rtl/bs_nal_wr_ctrl.sv
// bs_nal_wr_ctrl: turns an Annex-B byte stream into NAL payloads in two ping-pong RAM banks,
// dropping start codes, emulation-prevention bytes and trailing zeros.
module bs_nal_wr_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        din,
    input  logic              din_vld,
    input  logic              din_last,
    output logic              din_rdy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              frame_done,
    output logic              frame_bank,
    output logic [ADDR_W-1:0] frame_len,
    input  logic              rel_vld,
    input  logic              rel_bank,
    output logic [1:0]        bank_full,
    output logic              err_ovf,
    output logic              stream_end
);
    localparam logic [ADDR_W-1:0] DEPTH = {1'b1, {(ADDR_W-1){1'b0}}};

    typedef enum logic [2:0] {SEARCH, PAYLOAD, FLUSH, WAIT_BANK, DONE} state_t;

    state_t            state;
    logic              cur_bank;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] off_nxt;
    logic [1:0]        zero_cnt;
    logic [1:0]        zero_inc;
    logic [1:0]        fl_zeros;
    logic [7:0]        fl_byte;
    logic              fl_has;
    logic              fl_last;
    logic              acc;
    logic              zc2;
    logic              is_zero;
    logic              start;
    logic              ep;
    logic              fl_done;
    logic              wr_req;
    logic              wr_ok;
    logic [7:0]        wr_byte;
    logic              close;
    logic              close_nal;

    assign din_rdy = (state == SEARCH || state == PAYLOAD) && !stream_end;

    always_comb begin
        acc       = din_vld && din_rdy;
        zc2       = zero_cnt == 2'd2;
        is_zero   = din == 8'h00;
        start     = din == 8'h01 && zc2;
        ep        = din == 8'h03 && zc2;
        zero_inc  = zc2 ? 2'd2 : zero_cnt + 2'd1;
        fl_done   = fl_zeros == 2'd0 || (fl_zeros == 2'd1 && !fl_has);
        wr_req    = state == FLUSH || (state == PAYLOAD && acc && !is_zero && !start && !ep);
        wr_byte   = state == FLUSH ? (fl_zeros != 2'd0 ? 8'h00 : fl_byte)
                                   : (zero_cnt != 2'd0 ? 8'h00 : din);
        wr_ok     = wr_req && offset != DEPTH;
        off_nxt   = offset + {{(ADDR_W-1){1'b0}}, wr_ok};
        // A last byte that still has zeros to flush closes only once FLUSH drains.
        close     = state == FLUSH ? fl_done && fl_last
                                   : state == PAYLOAD && acc && (start || (din_last && (is_zero || zero_cnt == 2'd0)));
        close_nal = close && off_nxt != '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SEARCH;
            cur_bank   <= 1'b0;
            offset     <= '0;
            zero_cnt   <= 2'd0;
            fl_zeros   <= 2'd0;
            fl_byte    <= 8'h00;
            fl_has     <= 1'b0;
            fl_last    <= 1'b0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= 8'h00;
            frame_done <= 1'b0;
            frame_bank <= 1'b0;
            frame_len  <= '0;
            bank_full  <= 2'b00;
            err_ovf    <= 1'b0;
            stream_end <= 1'b0;
        end else begin
            ram_we     <= wr_ok;
            frame_done <= 1'b0;
            offset     <= off_nxt;
            if (wr_ok) begin
                ram_waddr <= {cur_bank, offset[ADDR_W-2:0]};
                ram_wdata <= wr_byte;
            end
            if (wr_req && !wr_ok)
                err_ovf <= 1'b1;
            if (rel_vld)
                bank_full[rel_bank] <= 1'b0;
            // Placed after the release so a same-bank set wins.
            if (close_nal) begin
                frame_done          <= 1'b1;
                frame_bank          <= cur_bank;
                frame_len           <= off_nxt;
                bank_full[cur_bank] <= 1'b1;
                cur_bank            <= !cur_bank;
                offset              <= '0;
            end
            case (state)
                SEARCH: if (acc) begin
                    zero_cnt <= is_zero ? zero_inc : 2'd0;
                    if (start)
                        state <= PAYLOAD;
                    if (din_last) begin
                        stream_end <= 1'b1;
                        state      <= DONE;
                    end
                end
                PAYLOAD: if (acc) begin
                    zero_cnt <= is_zero ? zero_inc : 2'd0;
                    fl_last  <= din_last;
                    if (ep) begin
                        fl_zeros <= 2'd2;
                        fl_has   <= 1'b0;
                        state    <= FLUSH;
                    end else if (!is_zero && !start && zero_cnt != 2'd0) begin
                        fl_zeros <= zero_cnt - 2'd1;
                        fl_byte  <= din;
                        fl_has   <= 1'b1;
                        state    <= FLUSH;
                    end else if (din_last) begin
                        stream_end <= 1'b1;
                        state      <= DONE;
                    end else if (close_nal && bank_full[!cur_bank]) begin
                        state <= WAIT_BANK;
                    end
                end
                FLUSH: begin
                    if (fl_zeros != 2'd0)
                        fl_zeros <= fl_zeros - 2'd1;
                    if (fl_done) begin
                        state <= fl_last ? DONE : PAYLOAD;
                        if (fl_last)
                            stream_end <= 1'b1;
                    end
                end
                WAIT_BANK: if (!bank_full[cur_bank]) state <= PAYLOAD;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bs_nal_wr_ctrl.sv
// tb_bs_nal_wr_ctrl: directed and random Annex-B streams checked against a byte-level NAL model.
module tb_bs_nal_wr_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          din_vld = 1'b0;
    logic          din_last = 1'b0;
    logic          din_rdy;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic          frame_done;
    logic          frame_bank;
    logic [AW-1:0] frame_len;
    logic          rel_vld;
    logic          rel_bank;
    logic [1:0]    bank_full;
    logic          err_ovf;
    logic          stream_end;

    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_w[$];
    int         exp_f[$];
    logic [7:0] stim[$];
    logic [7:0] m_cur[$];
    bit         m_bank;
    bit         m_ovf;
    bit         chk_en = 1'b0;
    bit         auto_rel = 1'b0;
    int         man_req = 0;
    int         man_done = 0;
    bit         man_bank = 1'b0;
    bit         relq[$];

    always #5 clk = ~clk;

    bs_nal_wr_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_last(din_last),
        .din_rdy(din_rdy), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .frame_done(frame_done), .frame_bank(frame_bank), .frame_len(frame_len),
        .rel_vld(rel_vld), .rel_bank(rel_bank), .bank_full(bank_full),
        .err_ovf(err_ovf), .stream_end(stream_end)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    // Model: one NAL closes into the next bank; payload truncated to DEPTH.
    task automatic m_close();
        int sz;
        sz = m_cur.size();
        if (sz > 0) begin
            for (int j = 0; j < sz && j < DEPTH; j++)
                exp_w.push_back((int'(m_bank) << 11) | (j << 8) | int'(m_cur[j]));
            exp_f.push_back((int'(m_bank) << 4) | (sz > DEPTH ? DEPTH : sz));
            if (sz > DEPTH) m_ovf = 1'b1;
            m_bank = !m_bank;
            m_cur.delete();
        end
    endtask

    task automatic model();
        int z;
        bit in_nal;
        logic [7:0] b;
        z = 0;
        in_nal = 1'b0;
        m_bank = 1'b0;
        m_ovf = 1'b0;
        m_cur.delete();
        foreach (stim[i]) begin
            b = stim[i];
            if (!in_nal) begin
                if (b == 8'h00) z = (z < 2) ? z + 1 : 2;
                else begin
                    in_nal = (b == 8'h01 && z == 2);
                    z = 0;
                end
            end else if (b == 8'h00) z = (z < 2) ? z + 1 : 2;
            else if (b == 8'h01 && z == 2) begin
                m_close();
                z = 0;
            end else if (b == 8'h03 && z == 2) begin
                m_cur.push_back(8'h00);
                m_cur.push_back(8'h00);
                z = 0;
            end else begin
                repeat (z) m_cur.push_back(8'h00);
                m_cur.push_back(b);
                z = 0;
            end
        end
        if (in_nal) m_close();
    endtask

    task automatic send(input logic [7:0] b, input bit last, output int stall);
        din = b;
        din_last = last;
        din_vld = 1'b1;
        stall = 0;
        @(negedge clk);
        while (!din_rdy && stall < 400) begin
            stall++;
            @(negedge clk);
        end
        if (!din_rdy) begin
            chk("din_accept_timeout", 0, 1);
            summary();
        end
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        din_last = 1'b0;
    endtask

    task automatic run_stream(input bit gaps);
        int st;
        foreach (stim[i]) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            send(stim[i], i == stim.size() - 1, st);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_vld = 1'b0;
        din_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic finish_test(input string tag);
        int n;
        n = 0;
        while (!stream_end && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_stream_end"}, int'(stream_end), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_err_ovf"}, int'(err_ovf), int'(m_ovf));
        chk({tag, "_rdy_done"}, int'(din_rdy), 0);
        chk({tag, "_writes_left"}, exp_w.size(), 0);
        chk({tag, "_frames_left"}, exp_f.size(), 0);
        exp_w.delete();
        exp_f.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_stream();
        int nn;
        int len;
        int r;
        stim.delete();
        repeat ($urandom_range(0, 3)) stim.push_back(8'($urandom_range(2, 255)));
        nn = $urandom_range(1, 5);
        for (int k = 0; k < nn; k++) begin
            if ($urandom_range(0, 3) == 0) stim.push_back(8'h00);
            stim.push_back(8'h00);
            stim.push_back(8'h00);
            stim.push_back(8'h01);
            len = $urandom_range(0, 11);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 9);
                stim.push_back(r < 3 ? 8'h00 : r == 3 ? 8'h03 : r == 4 ? 8'h01 : 8'($urandom_range(4, 255)));
            end
        end
        if ($urandom_range(0, 1) == 1) begin
            stim.push_back(8'h55);
            stim.push_back(8'hAA);
        end else begin
            stim.push_back(8'h00);
            stim.push_back(8'h00);
            stim.push_back(8'h01);
        end
    endtask

    // Write/frame scoreboard against the model queues.
    initial forever begin
        @(negedge clk);
        if (chk_en && ram_we) begin
            if (exp_w.size() == 0) chk("ram_write_unexpected", int'({ram_waddr, ram_wdata}), -1);
            else chk("ram_write", int'({ram_waddr, ram_wdata}), exp_w.pop_front());
        end
        if (chk_en && frame_done) begin
            if (exp_f.size() == 0) chk("frame_unexpected", int'({frame_bank, frame_len}), -1);
            else chk("frame_done", int'({frame_bank, frame_len}), exp_f.pop_front());
        end
    end

    // Consumer: releases completed banks, either on request or randomly in order.
    initial begin
        rel_vld = 1'b0;
        rel_bank = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rel_vld = 1'b0;
            if (!rst_n) relq.delete();
            else if (auto_rel && frame_done) relq.push_back(frame_bank);
            if (man_req != man_done) begin
                rel_bank = man_bank;
                rel_vld = 1'b1;
                man_done++;
            end else if (auto_rel && relq.size() > 0 && $urandom_range(0, 2) == 0) begin
                rel_bank = relq.pop_front();
                rel_vld = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        do_reset();
        @(negedge clk);
        chk("rst_din_rdy", int'(din_rdy), 1);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_bank_full", int'(bank_full), 0);
        chk("rst_err_ovf", int'(err_ovf), 0);
        chk("rst_stream_end", int'(stream_end), 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        stim = '{8'h11, 8'h00, 8'h00, 8'h01, 8'h40, 8'h01, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h42};
        model();
        chk("model_t1_f0", exp_f[0], 'h03);
        chk("model_t1_f1", exp_f[1], 'h11);
        chk("model_t1_w1", exp_w[1], 'h101);
        chk("model_t1_w3", exp_w[3], 'h842);
        run_stream(1'b0);
        finish_test("t1");
        chk("t1_bank_full", int'(bank_full), 3);

        do_reset();
        stim = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h01};
        model();
        chk("model_t2_f0", exp_f[0], 'h03);
        chk("model_t2_w2", exp_w[2], 'h201);
        for (int i = 0; i < 6; i++) send(stim[i], 1'b0, st);
        send(8'h01, 1'b1, st);
        chk("t2_ep_stall", st, 2);
        finish_test("t2");

        do_reset();
        stim = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h26};
        model();
        chk("model_t3_nf", exp_f.size(), 1);
        chk("model_t3_w0", exp_w[0], 'h026);
        run_stream(1'b0);
        finish_test("t3");

        do_reset();
        stim = '{8'h00, 8'h00, 8'h01, 8'hA1, 8'h00, 8'h00, 8'h01, 8'hB2, 8'h00, 8'h00, 8'h01, 8'hC3};
        model();
        chk("model_t4_f1", exp_f[1], 'h11);
        chk("model_t4_w2", exp_w[2], 'h0C3);
        for (int i = 0; i < 11; i++) send(stim[i], 1'b0, st);
        repeat (3) @(negedge clk);
        chk("t4_wait_rdy", int'(din_rdy), 0);
        chk("t4_wait_full", int'(bank_full), 3);
        @(posedge clk);
        #1;
        man_bank = 1'b0;
        man_req++;
        @(negedge clk);
        chk("t4_rel_rdy0", int'(din_rdy), 0);
        @(negedge clk);
        chk("t4_rel_rdy1", int'(din_rdy), 0);
        chk("t4_rel_full", int'(bank_full), 2);
        @(negedge clk);
        chk("t4_rel_rdy2", int'(din_rdy), 1);
        @(posedge clk);
        #1;
        send(8'hC3, 1'b1, st);
        finish_test("t4");

        do_reset();
        stim = '{8'h00, 8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
        model();
        chk("model_t5_f0", exp_f[0], 'h08);
        chk("model_t5_nw", exp_w.size(), 8);
        chk("model_t5_ovf", int'(m_ovf), 1);
        run_stream(1'b0);
        finish_test("t5");

        do_reset();
        chk_en = 1'b0;
        stim = '{8'h00, 8'h00, 8'h01, 8'h77, 8'h00, 8'h00, 8'h01, 8'h88, 8'h00, 8'h00, 8'h45};
        foreach (stim[i]) send(stim[i], 1'b0, st);
        @(negedge clk);
        chk("t6_pre_we", int'(ram_we), 1);
        chk("t6_pre_full", int'(bank_full), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rst_we", int'(ram_we), 0);
        chk("t6_rst_full", int'(bank_full), 0);
        chk("t6_rst_rdy", int'(din_rdy), 1);
        @(negedge clk);
        chk("t6_rst_we_next", int'(ram_we), 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        stim = '{8'h00, 8'h00, 8'h01, 8'h5A};
        model();
        chk("model_t6_w0", exp_w[0], 'h05A);
        run_stream(1'b0);
        finish_test("t6");

        auto_rel = 1'b1;
        for (int t = 0; t < 30; t++) begin
            do_reset();
            gen_stream();
            model();
            run_stream(1'b1);
            finish_test("rnd");
        end
        summary();
    end
endmodule

// File: doc/bs_nal_wr_ctrl.md
Name: bs_nal_wr_ctrl

Overview:
Sequences the bitstream RAM write side. Consumes the raw Annex-B byte stream (bytes from the file loader or host), finds 00 00 01 start codes, strips start codes, emulation-prevention bytes (00 00 03) and trailing zeros, and writes each NAL payload into one of two ping-pong RAM banks. It tells the CABAC/parser side when a bank holds a complete NAL and waits for that side to release the bank before reusing it.

Parameters:
ADDR_W, 12, RAM address width; MSB selects the bank, so each bank holds BANK_DEPTH = 2^(ADDR_W-1) bytes.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
din  in  8  stream byte
din_vld  in  1  din valid
din_last  in  1  with din_vld, marks the last byte of the stream
din_rdy  out  1  byte accepted when din_vld & din_rdy
ram_we  out  1  RAM write strobe
ram_waddr  out  ADDR_W  {bank, offset}
ram_wdata  out  8  write data
frame_done  out  1  1-cycle pulse; a bank now holds a complete NAL
frame_bank  out  1  bank of the completed NAL, valid with frame_done
frame_len  out  ADDR_W  payload bytes of the completed NAL, valid with frame_done
rel_vld  in  1  consumer releases bank rel_bank
rel_bank  in  1  bank being released
bank_full  out  2  per-bank occupied flags
err_ovf  out  1  sticky; a NAL exceeded BANK_DEPTH
stream_end  out  1  sticky; din_last processed

Behaviour:
- Reset values: all outputs 0, except din_rdy, which is 1 in SEARCH. cur_bank=0, offset=0, zero_cnt=0, state SEARCH.
- Registered outputs. A byte accepted in cycle t gives its RAM write at t+1.
- zero_cnt (0..2) counts pending 00 bytes that have not been written yet.
- din_rdy = 1 only in SEARCH or PAYLOAD, and 0 once stream_end is set.
- SEARCH:
  - Discard bytes and track zero_cnt.
  - A 01 byte with zero_cnt==2 gives: offset=0, zero_cnt=0, go to PAYLOAD.
  - Any other non-zero byte clears zero_cnt.
- PAYLOAD, per accepted byte:
  - 00 with zero_cnt<2: zero_cnt++. No write.
  - 00 with zero_cnt==2: dropped as a trailing zero. zero_cnt stays 2.
  - 01 with zero_cnt==2: start code. Close the NAL (see below). Pending zeros are dropped.
  - 03 with zero_cnt==2: emulation-prevention byte, dropped. Go to FLUSH with 2 zeros to write, then return to PAYLOAD with zero_cnt=0.
  - Any other byte X with zero_cnt=k: if k==0, write X at t+1 and offset++. If k>0, go to FLUSH and write k zeros and then X, one per cycle, with din_rdy=0 throughout. Example: 00 00 45 writes 00 at t+1, 00 at t+2, 45 at t+3.
- FLUSH: emits one pending byte per cycle, then returns to PAYLOAD.
- Overflow: a write with offset==BANK_DEPTH is suppressed and sets err_ovf. Later bytes of that NAL are dropped, but start codes are still detected. The closed length is BANK_DEPTH.
- Close NAL:
  - offset==0 (empty NAL, e.g. back-to-back start codes): no frame_done; keep the current bank.
  - Otherwise, at t+1: frame_done=1, frame_bank=cur_bank, frame_len=offset, bank_full[cur_bank]=1, cur_bank toggles, offset=0.
  - If bank_full of the new bank is 1, go to WAIT_BANK; else go to PAYLOAD.
- WAIT_BANK: din_rdy=0. When rel_vld for cur_bank arrives, go to PAYLOAD in the next cycle.
- rel_vld clears bank_full[rel_bank] next cycle.
- Release and set of the same bank in the same cycle: set wins.
- Release of a bank that is not full: ignored.
- din_last on an accepted byte:
  - Process the byte first.
  - Drop pending zeros.
  - If offset>0, close the NAL as above, with no bank wait.
  - Set stream_end and go to DONE. DONE keeps din_rdy=0 until reset.
  - A din_last byte that is itself 01 with zero_cnt==2 closes the NAL and then ends the stream.
- Reset mid-operation: all state, including bank_full and the sticky flags, returns to reset values on the next clk edge. A write in progress is abandoned.

Test Plan:
- Stream 11 00 00 01 40 01 0C 00 00 01 42 (last on 42) -> writes 40,01,0C to bank0 addr 0..2; frame_done with frame_bank=0, frame_len=3; then 42 at bank1 offset 0; second frame_done with frame_bank=1, frame_len=1; stream_end=1.
- Payload 00 00 03 01 inside a NAL -> RAM gets 00,00,01 and no 03; din_rdy low for 2 cycles; length counts 3.
- 00 00 01 00 00 01 26 -> no frame_done for the empty NAL; 26 written to bank0 offset 0.
- Three NALs with no rel_vld -> after the second frame_done, din_rdy stays 0 in WAIT_BANK; rel_vld with rel_bank=0 -> din_rdy=1 two cycles later and the third NAL is written to bank0.
- ADDR_W=4 (BANK_DEPTH=8), 10-byte NAL -> 8 writes, err_ovf=1, frame_len=8.
- Assert rst_n=0 for one cycle mid-FLUSH -> ram_we=0, bank_full=0, din_rdy=1, state SEARCH.
